// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared widths, FSM encoding and address check for the dmem arbiter
package dmem_arb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int PORT_W = 1;
  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;
  // Unsigned 32-bit compare, so addresses near 2^32 are rejected rather than wrapping.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int unsigned mem_bytes);
    return (addr[1:0] == 2'b00) && (addr <= ADDR_W'(mem_bytes - 4));
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant, the port not granted last wins a tie
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic last_grant;
  always_comb gnt = (req == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk or posedge rst)
    if (rst) last_grant <= 1'b1;
    else if (advance) last_grant <= gnt[1];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one dmem between two valid/ready ports, rejecting misaligned or out-of-range accesses
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_BYTES = 32,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p0_req_valid,
  output logic                 p0_req_ready,
  input  logic                 p0_req_we,
  input  logic [ADDR_W-1:0]    p0_req_addr,
  input  logic [DATA_W-1:0]    p0_req_wdata,
  output logic                 p0_rsp_valid,
  output logic [DATA_W-1:0]    p0_rsp_rdata,
  output logic                 p0_rsp_err,
  input  logic                 p1_req_valid,
  output logic                 p1_req_ready,
  input  logic                 p1_req_we,
  input  logic [ADDR_W-1:0]    p1_req_addr,
  input  logic [DATA_W-1:0]    p1_req_wdata,
  output logic                 p1_rsp_valid,
  output logic [DATA_W-1:0]    p1_rsp_rdata,
  output logic                 p1_rsp_err,
  output logic                 mem_write_en,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_write_data,
  input  logic [DATA_W-1:0]    mem_read_data,
  output logic [ERR_CNT_W-1:0] err_count
);
  state_t state, state_nxt;
  logic [1:0] req, gnt, rsp_valid, rsp_err;
  logic [1:0][DATA_W-1:0] rsp_rdata;
  logic accept, ok, we;
  logic [PORT_W-1:0] port;
  rr_arb2 u_arb (.clk(clk), .rst(rst), .req(req), .advance(accept), .gnt(gnt));
  // Requests are only visible to the arbiter in IDLE and outside reset, so ready stays low otherwise.
  always_comb begin
    req = (state == ST_IDLE && !rst) ? {p1_req_valid, p0_req_valid} : 2'b00;
    accept = |gnt;
    ok = addr_ok(mem_addr, MEM_BYTES);
    mem_write_en = (state == ST_ACCESS) && we && ok;
    state_nxt = accept ? ST_ACCESS : ST_IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      port <= '0;
      we <= 1'b0;
      mem_addr <= '0;
      mem_write_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        port <= gnt[1];
        we <= gnt[1] ? p1_req_we : p0_req_we;
        mem_addr <= gnt[1] ? p1_req_addr : p0_req_addr;
        mem_write_data <= gnt[1] ? p1_req_wdata : p0_req_wdata;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rsp_valid <= '0;
      rsp_err <= '0;
      rsp_rdata <= '0;
      err_count <= '0;
    end else begin
      rsp_valid <= '0;
      if (state == ST_ACCESS) begin
        rsp_valid[port] <= 1'b1;
        rsp_err[port] <= !ok;
        rsp_rdata[port] <= (!we && ok) ? mem_read_data : '0;
        if (!ok && !(&err_count)) err_count <= err_count + 1'b1;
      end
    end
  assign p0_req_ready = gnt[0];
  assign p1_req_ready = gnt[1];
  assign p0_rsp_valid = rsp_valid[0];
  assign p1_rsp_valid = rsp_valid[1];
  assign p0_rsp_err = rsp_err[0];
  assign p1_rsp_err = rsp_err[1];
  assign p0_rsp_rdata = rsp_rdata[0];
  assign p1_rsp_rdata = rsp_rdata[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
  localparam int MEM_BYTES = 32;
  localparam int ERR_W = 8;
  localparam int SAT = (1 << ERR_W) - 1;
  logic clk = 1'b0, rst = 1'b0;
  logic p0_req_valid = 1'b0, p0_req_we = 1'b0, p1_req_valid = 1'b0, p1_req_we = 1'b0;
  logic [31:0] p0_req_addr = '0, p0_req_wdata = '0, p1_req_addr = '0, p1_req_wdata = '0;
  logic p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
  logic [31:0] p0_rsp_rdata, p1_rsp_rdata, mem_addr, mem_write_data, mem_read_data;
  logic mem_write_en;
  logic [ERR_W-1:0] err_count;
  logic [31:0] dmem [8];
  logic [31:0] ref_mem [8];
  logic load = 1'b0;
  int vectors = 0, miscompares = 0, model_err = 0, model_last = 1, wen_cycles = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .ERR_CNT_W(ERR_W)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .err_count(err_count)
  );

  // Attached 32-byte dmem: combinational read, write on the clock edge.
  assign mem_read_data = dmem[mem_addr[4:2]];
  always @(posedge clk) begin
    if (mem_write_en) begin
      dmem[mem_addr[4:2]] <= mem_write_data;
      wen_cycles <= wen_cycles + 1;
    end
    if (load) for (int i = 0; i < 8; i++) dmem[i] <= ref_mem[i];
  end

  // Transaction-level model: what a single accepted access should return and do.
  task automatic model(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] erd, output logic eer);
    logic ok;
    ok = (a % 4 == 0) && ({32'd0, a} + 64'd4 <= 64'(MEM_BYTES));
    eer = !ok;
    erd = (ok && !we) ? ref_mem[a >> 2] : 32'd0;
    if (ok && we) ref_mem[a >> 2] = wd;
    if (!ok) model_err++;
    model_last = p;
  endtask

  // Issues one request on port p and samples both ports' response pulses for three cycles after accept.
  task automatic do_txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output logic [2:0] pv, output logic ov);
    int n;
    pv = '0; ov = 1'b0; rd = '0; er = 1'b0;
    @(negedge clk);
    if (p == 0) begin
      p0_req_we = we; p0_req_addr = a; p0_req_wdata = wd; p0_req_valid = 1'b1;
    end else begin
      p1_req_we = we; p1_req_addr = a; p1_req_wdata = wd; p1_req_valid = 1'b1;
    end
    #1;
    n = 0;
    while (((p == 0) ? p0_req_ready : p1_req_ready) !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n == 20) begin
      p0_req_valid = 1'b0; p1_req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      pv[k] = (p == 0) ? p0_rsp_valid : p1_rsp_valid;
      ov = ov | ((p == 0) ? p1_rsp_valid : p0_rsp_valid);
      if (k == 1) begin
        rd = (p == 0) ? p0_rsp_rdata : p1_rsp_rdata;
        er = (p == 0) ? p0_rsp_err : p1_rsp_err;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    p0_req_valid = 1'b1; p1_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) ref_mem[i] = $urandom;
    load = 1'b1;
    repeat (2) @(negedge clk);
    load = 1'b0;
    #1;
    vectors++;
    if ({p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err, mem_write_en} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0000000", {p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err, mem_write_en});
    end
    vectors++;
    if (p0_rsp_rdata !== 32'd0 || p1_rsp_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h %h want 0 0", p0_rsp_rdata, p1_rsp_rdata);
    end
    vectors++;
    if (mem_addr !== 32'd0 || mem_write_data !== 32'd0 || err_count !== '0) begin
      miscompares++;
      $display("FAIL reset_mem: addr=%h wdata=%h errcnt=%h want 0 0 0", mem_addr, mem_write_data, err_count);
    end
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_both;
    int w, prev;
    logic [31:0] a [2];
    a[0] = 32'h0; a[1] = 32'h10;
    prev = -1;
    @(negedge clk);
    p0_req_we = 1'b0; p0_req_addr = a[0]; p1_req_we = 1'b0; p1_req_addr = a[1];
    p0_req_valid = 1'b1; p1_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (prev >= 0) begin
        vectors++;
        if ({p1_rsp_valid, p0_rsp_valid} !== (prev == 1 ? 2'b10 : 2'b01) ||
            (prev == 1 ? p1_rsp_rdata : p0_rsp_rdata) !== ref_mem[a[prev] >> 2]) begin
          miscompares++;
          $display("FAIL both_rsp[%0d]: valid=%b rdata0=%h rdata1=%h want port %0d data %h",
                   i, {p1_rsp_valid, p0_rsp_valid}, p0_rsp_rdata, p1_rsp_rdata, prev, ref_mem[a[prev] >> 2]);
        end
      end
      if (i == 4) break;
      w = (model_last == 1) ? 0 : 1;
      vectors++;
      if ({p1_req_ready, p0_req_ready} !== (w == 1 ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL both_grant[%0d]: ready=%b want port %0d", i, {p1_req_ready, p0_req_ready}, w);
      end
      model_last = w; prev = w;
      @(negedge clk); #1;
      vectors++;
      if ({p1_req_ready, p0_req_ready, p1_rsp_valid, p0_rsp_valid} !== 4'b0) begin
        miscompares++;
        $display("FAIL both_access[%0d]: ready/rsp=%b want 0000", i, {p1_req_ready, p0_req_ready, p1_rsp_valid, p0_rsp_valid});
      end
      @(negedge clk);
    end
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
  endtask

  task automatic test_write_read;
    logic [31:0] rd, erd; logic er, eer, ov; logic [2:0] pv;
    logic we_t [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      do_txn(0, we_t[i], 32'h4, 32'hDEADBEEF, rd, er, pv, ov);
      model(0, we_t[i], 32'h4, 32'hDEADBEEF, erd, eer);
      vectors++;
      if (rd !== erd || er !== eer || pv !== 3'b010 || ov !== 1'b0) begin
        miscompares++;
        $display("FAIL wr_rd[%0d]: rdata=%h err=%b pulses=%b other=%b want rdata=%h err=%b pulses=010 other=0", i, rd, er, pv, ov, erd, eer);
      end
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd, erd; logic er, eer, ov; logic [2:0] pv;
    logic we_t [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] a_t [3] = '{32'h5, 32'h20, 32'h1C};
    int wc;
    wc = wen_cycles;
    for (int i = 0; i < 3; i++) begin
      do_txn(1, we_t[i], a_t[i], 32'h12345678, rd, er, pv, ov);
      model(1, we_t[i], a_t[i], 32'h12345678, erd, eer);
      vectors++;
      if (rd !== erd || er !== eer || pv !== 3'b010 || ov !== 1'b0) begin
        miscompares++;
        $display("FAIL err_txn[%0d]: rdata=%h err=%b pulses=%b other=%b want rdata=%h err=%b pulses=010 other=0", i, rd, er, pv, ov, erd, eer);
      end
    end
    vectors++;
    if (wen_cycles !== wc || err_count !== ERR_W'(model_err)) begin
      miscompares++;
      $display("FAIL err_side: write_en cycles=%0d errcnt=%0d want 0 and %0d", wen_cycles - wc, err_count, model_err);
    end
    vectors++;
    if (p0_rsp_rdata !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL rdata_hold: p0 rdata=%h want deadbeef", p0_rsp_rdata);
    end
  endtask

  task automatic test_boundary;
    logic [31:0] rd, erd; logic er, eer, ov; logic [2:0] pv;
    logic we_t [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] a_t [4] = '{32'h1C, 32'h1C, 32'hFFFFFFFC, 32'h18};
    for (int i = 0; i < 4; i++) begin
      do_txn(i % 2, we_t[i], a_t[i], 32'hAABBCCDD, rd, er, pv, ov);
      model(i % 2, we_t[i], a_t[i], 32'hAABBCCDD, erd, eer);
      vectors++;
      if (rd !== erd || er !== eer || pv !== 3'b010 || ov !== 1'b0) begin
        miscompares++;
        $display("FAIL bound[%0d]: rdata=%h err=%b pulses=%b other=%b want rdata=%h err=%b pulses=010 other=0", i, rd, er, pv, ov, erd, eer);
      end
    end
    vectors++;
    if (err_count !== ERR_W'(model_err)) begin
      miscompares++;
      $display("FAIL bound_errcnt: got %0d want %0d", err_count, model_err);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, erd, a, wd; logic er, eer, ov, we; logic [2:0] pv;
    int p;
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(0, 1);
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 5))
        0, 1: a = 32'($urandom_range(0, 7) * 4);
        2: a = 32'($urandom_range(0, 31));
        3: a = 32'h1C + 32'($urandom_range(0, 8));
        4: a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      do_txn(p, we, a, wd, rd, er, pv, ov);
      model(p, we, a, wd, erd, eer);
      vectors++;
      if (rd !== erd || er !== eer || pv !== 3'b010 || ov !== 1'b0 || err_count !== ERR_W'(model_err)) begin
        miscompares++;
        $display("FAIL rand[%0d] p%0d we=%b a=%h: rdata=%h err=%b pulses=%b other=%b errcnt=%0d want rdata=%h err=%b pulses=010 other=0 errcnt=%0d",
                 i, p, we, a, rd, er, pv, ov, err_count, erd, eer, model_err);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd, erd; logic er, eer, ov; logic [2:0] pv;
    int wc, n, pulses;
    wc = wen_cycles;
    @(negedge clk);
    p0_req_we = 1'b1; p0_req_addr = 32'h8; p0_req_wdata = 32'h55; p0_req_valid = 1'b1;
    n = 0;
    #1;
    while (p0_req_ready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    #2 rst = 1'b1;
    p0_req_valid = 1'b0;
    #1;
    vectors++;
    if (n == 20 || {mem_write_en, p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err} !== 7'b0 ||
        mem_addr !== 32'd0 || mem_write_data !== 32'd0 || err_count !== '0 || p0_rsp_rdata !== 32'd0 || p1_rsp_rdata !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset_out: accepted=%b ctrl=%b addr=%h wdata=%h errcnt=%0d want accepted=1 and all zero",
               n < 20, {mem_write_en, p0_req_ready, p1_req_ready, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err},
               mem_addr, mem_write_data, err_count);
    end
    model_err = 0; model_last = 1;
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      pulses += int'(p0_rsp_valid) + int'(p1_rsp_valid);
    end
    vectors++;
    if (pulses != 0 || wen_cycles != wc) begin
      miscompares++;
      $display("FAIL mid_reset_side: rsp pulses=%0d writes=%0d want 0 0", pulses, wen_cycles - wc);
    end
    do_txn(0, 1'b0, 32'h8, 32'h0, rd, er, pv, ov);
    model(0, 1'b0, 32'h8, 32'h0, erd, eer);
    vectors++;
    if (rd !== erd || er !== eer || pv !== 3'b010) begin
      miscompares++;
      $display("FAIL mid_reset_read: rdata=%h err=%b pulses=%b want rdata=%h err=%b pulses=010", rd, er, pv, erd, eer);
    end
  endtask

  task automatic test_saturate;
    logic [31:0] rd, erd; logic er, eer, ov; logic [2:0] pv;
    for (int i = 0; i < SAT + 4; i++) begin
      do_txn(i % 2, 1'(i % 3 == 0), 32'h1 + 32'(i % 3), 32'h0, rd, er, pv, ov);
      model(i % 2, 1'(i % 3 == 0), 32'h1 + 32'(i % 3), 32'h0, erd, eer);
      if (i == SAT / 2) begin
        vectors++;
        if (err_count !== ERR_W'(model_err)) begin
          miscompares++;
          $display("FAIL sat_mid: errcnt=%0d want %0d", err_count, model_err);
        end
      end
    end
    vectors++;
    if (err_count !== ERR_W'(SAT) || er !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_reach: errcnt=%0d err=%b want %0d 1", err_count, er, SAT);
    end
    do_txn(0, 1'b0, 32'h2, 32'h0, rd, er, pv, ov);
    model(0, 1'b0, 32'h2, 32'h0, erd, eer);
    vectors++;
    if (err_count !== ERR_W'(SAT) || er !== eer || pv !== 3'b010) begin
      miscompares++;
      $display("FAIL sat_hold: errcnt=%0d err=%b pulses=%b want %0d %b 010", err_count, er, pv, SAT, eer);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_both();
    test_write_read();
    test_errors();
    test_boundary();
    test_random();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
